// File: rtl/turf_cmd_serializer_pkg.sv
// Shared definitions for the TURF command-line serializer.
//   - Record/frame field widths and the START/STOP line levels.
//   - Serializer FSM state encoding.
//   - build_frame(): turns a {buf, evid} record into the 37-bit on-wire frame.
package turf_cmd_serializer_pkg;

  localparam int unsigned BUF_BITS   = 2;
  localparam int unsigned EVID_BITS  = 32;
  localparam int unsigned REC_BITS   = BUF_BITS + EVID_BITS;   // 34
  localparam int unsigned FRAME_BITS = REC_BITS + 3;           // 37: START + data + PAR + STOP

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT
  } state_e;

  // Frame is sent MSB first: START, buf[1:0], evid[31:0], PAR, STOP.
  // PAR is even parity, so XOR over data bits plus PAR is zero.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [REC_BITS-1:0] rec);
    return {START_BIT, rec, ^rec, STOP_BIT};
  endfunction

endpackage

// File: rtl/turf_cmd_fifo.sv
// Synchronous register FIFO holding pending trigger records.
// Ports:
//   clk_i, rst_n_i   clock, asynchronous active-low reset
//   push_i, data_i   write request and record (ignored when full)
//   pop_i, data_o    read request and head record (data_o valid when not empty)
//   full_o, empty_o  registered status flags
//   empty_next_o     empty flag as it will be after the current edge
module turf_cmd_fifo #(
  parameter int unsigned DEPTH_LOG2 = 2,
  parameter int unsigned WIDTH      = 34
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             empty_next_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  full_q, empty_q;
  logic                  push_ok, pop_ok;

  // Fullness is judged on the registered flag, before any same-cycle pop.
  assign push_ok = push_i && !full_q;
  assign pop_ok  = pop_i && !empty_q;

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CW'(1);
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  assign data_o       = mem_q[rd_ptr_q];
  assign full_o       = full_q;
  assign empty_o      = empty_q;
  assign empty_next_o = (count_d == '0);

endmodule

// File: rtl/turf_cmd_serializer.sv
// Serializes accepted trigger records onto the TURF->SURF command line.
// Ports:
//   clk33_i, rst_n_i  33 MHz clock, asynchronous active-low reset
//   trig_i            one-cycle strobe, record {trig_buf_i, trig_evid_i} valid
//   ovf_clear_i       clears the sticky overflow flag
//   cmd_o             serial command line, idle low
//   busy_o            FIFO non-empty or frame in progress
//   full_o            record FIFO full
//   overflow_o        sticky: a trigger was dropped
//   sent_count_o      completed frames, wrapping
module turf_cmd_serializer
  import turf_cmd_serializer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH_LOG2 = 2,
  parameter int unsigned BIT_DIV         = 1
) (
  input  logic                 clk33_i,
  input  logic                 rst_n_i,
  input  logic                 trig_i,
  input  logic [BUF_BITS-1:0]  trig_buf_i,
  input  logic [EVID_BITS-1:0] trig_evid_i,
  input  logic                 ovf_clear_i,
  output logic                 cmd_o,
  output logic                 busy_o,
  output logic                 full_o,
  output logic                 overflow_o,
  output logic [15:0]          sent_count_o
);

  localparam logic [7:0] DIV_LAST = 8'(BIT_DIV - 1);
  localparam logic [5:0] BIT_LAST = 6'(FRAME_BITS - 1);

  state_e                state_q;
  logic [FRAME_BITS-2:0] rest_q;     // frame bits still to be driven after the current one
  logic [7:0]            div_q;
  logic [5:0]            bit_q;
  logic                  cmd_q;
  logic                  busy_q;
  logic                  ovf_q;
  logic [15:0]           sent_count_q;

  logic                  fifo_pop;
  logic [REC_BITS-1:0]   fifo_data;
  logic                  fifo_full, fifo_empty, fifo_empty_next;
  logic [FRAME_BITS-1:0] frame;

  assign fifo_pop = (state_q == S_LOAD);
  assign frame    = build_frame(fifo_data);

  turf_cmd_fifo #(
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
    .WIDTH      (REC_BITS)
  ) u_fifo (
    .clk_i        (clk33_i),
    .rst_n_i      (rst_n_i),
    .push_i       (trig_i),
    .data_i       ({trig_buf_i, trig_evid_i}),
    .pop_i        (fifo_pop),
    .data_o       (fifo_data),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .empty_next_o (fifo_empty_next)
  );

  // Setting on a dropped trigger wins over a same-cycle clear.
  always_ff @(posedge clk33_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ovf_q <= 1'b0;
    end else if (trig_i && fifo_full) begin
      ovf_q <= 1'b1;
    end else if (ovf_clear_i) begin
      ovf_q <= 1'b0;
    end
  end

  // cmd_q holds the bit currently on the wire; rest_q holds the remainder,
  // so the line is a pure flop output and bit boundaries carry no logic skew.
  always_ff @(posedge clk33_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      rest_q       <= '0;
      div_q        <= '0;
      bit_q        <= '0;
      cmd_q        <= 1'b0;
      busy_q       <= 1'b0;
      sent_count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cmd_q <= 1'b0;
          if (!fifo_empty) begin
            state_q <= S_LOAD;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= !fifo_empty_next;
          end
        end
        S_LOAD: begin
          cmd_q   <= frame[FRAME_BITS-1];
          rest_q  <= frame[FRAME_BITS-2:0];
          div_q   <= '0;
          bit_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= S_SHIFT;
        end
        S_SHIFT: begin
          if (div_q == DIV_LAST) begin
            div_q <= '0;
            if (bit_q == BIT_LAST) begin
              sent_count_q <= sent_count_q + 16'd1;
              cmd_q        <= 1'b0;
              if (!fifo_empty) begin
                state_q <= S_LOAD;
                busy_q  <= 1'b1;
              end else begin
                state_q <= S_IDLE;
                busy_q  <= !fifo_empty_next;
              end
            end else begin
              bit_q  <= bit_q + 6'd1;
              cmd_q  <= rest_q[FRAME_BITS-2];
              rest_q <= {rest_q[FRAME_BITS-3:0], 1'b0};
            end
          end else begin
            div_q <= div_q + 8'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cmd_q   <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_o        = cmd_q;
  assign busy_o       = busy_q;
  assign full_o       = fifo_full;
  assign overflow_o   = ovf_q;
  assign sent_count_o = sent_count_q;

endmodule

// File: tb/tb_turf_cmd_serializer.sv
module tb_turf_cmd_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic        trig1 = 1'b0, clr1 = 1'b0;
  logic [1:0]  buf1 = '0;
  logic [31:0] evid1 = '0;
  logic        cmd1, busy1, full1, ovf1;
  logic [15:0] sent1;

  logic        trig3 = 1'b0, clr3 = 1'b0;
  logic [1:0]  buf3 = '0;
  logic [31:0] evid3 = '0;
  logic        cmd3, busy3, full3, ovf3;
  logic [15:0] sent3;

  logic tr1 [8192];
  logic tr3 [8192];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Sample k after edge E0 (where e0 = cyc read at E0) lands at index e0+1+k.
  always @(negedge clk) begin
    tr1[cyc % 8192] <= cmd1;
    tr3[cyc % 8192] <= cmd3;
  end

  turf_cmd_serializer #(.FIFO_DEPTH_LOG2(2), .BIT_DIV(1)) dut1 (
    .clk33_i(clk), .rst_n_i(rst_n), .trig_i(trig1), .trig_buf_i(buf1),
    .trig_evid_i(evid1), .ovf_clear_i(clr1), .cmd_o(cmd1), .busy_o(busy1),
    .full_o(full1), .overflow_o(ovf1), .sent_count_o(sent1)
  );

  turf_cmd_serializer #(.FIFO_DEPTH_LOG2(2), .BIT_DIV(3)) dut3 (
    .clk33_i(clk), .rst_n_i(rst_n), .trig_i(trig3), .trig_buf_i(buf3),
    .trig_evid_i(evid3), .ovf_clear_i(clr3), .cmd_o(cmd3), .busy_o(busy3),
    .full_o(full3), .overflow_o(ovf3), .sent_count_o(sent3)
  );

  function automatic logic rd(input bit sel, input int unsigned idx);
    return sel ? tr3[idx % 8192] : tr1[idx % 8192];
  endfunction

  // Rebuild a frame from the trace; steady=0 if any bit changed within its period.
  task automatic get_frame(input bit sel, input int unsigned base, input int unsigned div,
                           output logic [36:0] f, output bit steady);
    steady = 1'b1;
    for (int unsigned j = 0; j < 37; j++) begin
      logic b0;
      b0 = rd(sel, base + j*div);
      f[36-j] = b0;
      for (int unsigned m = 1; m < div; m++)
        if (rd(sel, base + j*div + m) !== b0) steady = 1'b0;
    end
  endtask

  task automatic apply_reset;
    trig1 = 0; clr1 = 0; trig3 = 0; clr3 = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic trig_dut1(input logic [1:0] b, input logic [31:0] e, output int unsigned e0);
    trig1 = 1'b1; buf1 = b; evid1 = e;
    @(posedge clk);
    e0 = cyc;
    @(negedge clk);
    trig1 = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset();
    checks++;
    if ({cmd1, busy1, full1, ovf1} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b need 0000", {cmd1, busy1, full1, ovf1});
    end
    checks++;
    if (sent1 !== 16'h0000) begin
      errors++; $display("FAIL reset_sent got %h need 0000", sent1);
    end
    checks++;
    if ({cmd3, busy3, full3, ovf3} !== 4'b0000 || sent3 !== 16'h0000) begin
      errors++; $display("FAIL reset_dut3 got %b/%h need 0000/0000", {cmd3, busy3, full3, ovf3}, sent3);
    end
  endtask

  task automatic test_single;
    int unsigned e0;
    logic [36:0] f, exp;
    bit st;
    apply_reset();
    exp = {1'b1, 2'b10, 32'h12345678, 1'b0, 1'b0};
    trig_dut1(2'd2, 32'h12345678, e0);
    checks++;
    if (busy1 !== 1'b1) begin
      errors++; $display("FAIL single_busy got %b need 1", busy1);
    end
    repeat (38) @(negedge clk);       // after E38: last STOP cycle
    checks++;
    if (sent1 !== 16'd0) begin
      errors++; $display("FAIL single_sent_early got %0d need 0", sent1);
    end
    @(negedge clk);                   // after E39
    checks++;
    if (sent1 !== 16'd1 || busy1 !== 1'b0) begin
      errors++; $display("FAIL single_done got sent=%0d busy=%b need 1/0", sent1, busy1);
    end
    checks++;
    if (rd(0, e0 + 2) !== 1'b0) begin
      errors++; $display("FAIL single_latency got cmd=%b after E1 need 0", rd(0, e0 + 2));
    end
    get_frame(0, e0 + 3, 1, f, st);
    checks++;
    if (f !== exp) begin
      errors++; $display("FAIL single_frame got %h need %h", f, exp);
    end
  endtask

  task automatic test_back_to_back;
    int unsigned e0 = 0, base;
    logic [36:0] f, exp;
    bit st;
    logic par_tab [5];
    par_tab = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};   // parity of evid 1..5
    apply_reset();
    for (int unsigned i = 1; i <= 6; i++) begin
      trig1 = 1'b1; buf1 = 2'd0; evid1 = 32'(i);
      @(posedge clk);
      if (i == 1) e0 = cyc;
      @(negedge clk);
      if (i == 4) begin
        checks++;
        if (full1 !== 1'b0) begin
          errors++; $display("FAIL burst_full_E3 got %b need 0", full1);
        end
      end
      if (i == 5) begin
        checks++;
        if (full1 !== 1'b1) begin
          errors++; $display("FAIL burst_full_E4 got %b need 1", full1);
        end
      end
      if (i == 6) begin
        checks++;
        if (ovf1 !== 1'b1) begin
          errors++; $display("FAIL burst_overflow got %b need 1", ovf1);
        end
      end
    end
    trig1 = 1'b0;
    repeat (187) @(negedge clk);      // after E192: fifth frame finished at E191
    checks++;
    if (sent1 !== 16'd5 || busy1 !== 1'b0) begin
      errors++; $display("FAIL burst_sent got %0d busy=%b need 5/0", sent1, busy1);
    end
    for (int unsigned k = 0; k < 5; k++) begin
      base = e0 + 3 + k*38;
      exp = {1'b1, 2'b00, 32'(k + 1), par_tab[k], 1'b0};
      get_frame(0, base, 1, f, st);
      checks++;
      if (f !== exp) begin
        errors++; $display("FAIL burst_frame%0d got %h need %h", k, f, exp);
      end
      checks++;
      if (rd(0, base + 37) !== 1'b0) begin
        errors++; $display("FAIL burst_gap%0d got %b need 0", k, rd(0, base + 37));
      end
    end
  endtask

  task automatic test_bit_div3;
    int unsigned e0;
    logic [36:0] f, exp;
    bit st;
    apply_reset();
    exp = {1'b1, 2'b11, 32'hFFFFFFFF, 1'b0, 1'b0};
    trig3 = 1'b1; buf3 = 2'd3; evid3 = 32'hFFFFFFFF;
    @(posedge clk);
    e0 = cyc;
    @(negedge clk);
    trig3 = 1'b0;
    repeat (112) @(negedge clk);      // after E112: last cycle of STOP
    checks++;
    if (sent3 !== 16'd0) begin
      errors++; $display("FAIL div3_sent_early got %0d need 0", sent3);
    end
    @(negedge clk);
    checks++;
    if (sent3 !== 16'd1) begin
      errors++; $display("FAIL div3_sent got %0d need 1", sent3);
    end
    get_frame(1, e0 + 3, 3, f, st);
    checks++;
    if (f !== exp) begin
      errors++; $display("FAIL div3_frame got %h need %h", f, exp);
    end
    checks++;
    if (st !== 1'b1 || rd(1, e0 + 2) !== 1'b0) begin
      errors++; $display("FAIL div3_bit_width got steady=%b pre=%b need 1/0", st, rd(1, e0 + 2));
    end
  endtask

  task automatic test_overflow_clear;
    int unsigned e0;
    apply_reset();
    for (int unsigned i = 0; i < 5; i++) trig_dut1(2'd0, 32'(i), e0);
    checks++;
    if (full1 !== 1'b1 || ovf1 !== 1'b0) begin
      errors++; $display("FAIL ovf_pre got full=%b ovf=%b need 1/0", full1, ovf1);
    end
    trig1 = 1'b1; clr1 = 1'b1;
    @(negedge clk);
    checks++;
    if (ovf1 !== 1'b1) begin
      errors++; $display("FAIL ovf_set_priority got %b need 1", ovf1);
    end
    trig1 = 1'b0;
    @(negedge clk);
    clr1 = 1'b0;
    checks++;
    if (ovf1 !== 1'b0) begin
      errors++; $display("FAIL ovf_clear got %b need 0", ovf1);
    end
  endtask

  task automatic test_reset_mid_frame;
    int unsigned e0, e1;
    logic [36:0] f, exp;
    bit st;
    apply_reset();
    trig_dut1(2'd3, 32'hFFFFFFFF, e0);
    trig_dut1(2'd1, 32'h00000001, e1);  // queued, must be discarded
    repeat (21) @(negedge clk);         // after E22: bit 20
    checks++;
    if (cmd1 !== 1'b1) begin
      errors++; $display("FAIL rst_bit20 got %b need 1", cmd1);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (cmd1 !== 1'b0 || sent1 !== 16'd0 || busy1 !== 1'b0) begin
      errors++; $display("FAIL rst_async got cmd=%b sent=%0d busy=%b need 0/0/0", cmd1, sent1, busy1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (cmd1 !== 1'b0 || busy1 !== 1'b0 || full1 !== 1'b0 || sent1 !== 16'd0) begin
      errors++; $display("FAIL rst_idle got cmd=%b busy=%b full=%b sent=%0d need 0/0/0/0",
                         cmd1, busy1, full1, sent1);
    end
    exp = {1'b1, 2'b01, 32'hA5A5A5A5, 1'b1, 1'b0};
    trig_dut1(2'd1, 32'hA5A5A5A5, e0);
    repeat (40) @(negedge clk);
    get_frame(0, e0 + 3, 1, f, st);
    checks++;
    if (f !== exp || sent1 !== 16'd1) begin
      errors++; $display("FAIL rst_clean_frame got %h sent=%0d need %h/1", f, sent1, exp);
    end
  endtask

  task automatic test_counter_wrap;
    int unsigned e0;
    apply_reset();
    force dut1.sent_count_q = 16'hFFFF;
    @(negedge clk);
    release dut1.sent_count_q;
    @(negedge clk);
    checks++;
    if (sent1 !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_preload got %h need ffff", sent1);
    end
    trig_dut1(2'd0, 32'h0, e0);
    repeat (40) @(negedge clk);
    checks++;
    if (sent1 !== 16'h0000) begin
      errors++; $display("FAIL wrap got %h need 0000", sent1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_bit_div3();
    test_overflow_clear();
    test_reset_mid_frame();
    test_counter_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
